mips_multicycle_core: RTL
=========================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width in bits (legal 16..64).
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 8..32).
REQ-003 SHALL have parameter DMEM_DEPTH, default 64, data-memory words (power of two).
REQ-004 SHALL have port clk  in  1  rising-edge clock; the only clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port inst  in  32  MIPS instruction word.
REQ-007 SHALL have port inst_valid  in  1  inst is offered.
REQ-008 SHALL have port inst_ready  out  1  core accepts inst this cycle.
REQ-009 SHALL have port aluresult  out  XLEN  registered ALU result.
REQ-010 SHALL have port writeonmem  out  XLEN  registered rt operand (store data).
REQ-011 SHALL have ports MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg  out  1 each  control strobes/selects.
REQ-012 SHALL have port ALUControl  out  3  ALU operation code.
REQ-013 SHALL have port pc  out  XLEN  program counter.
REQ-014 SHALL have ports done, branch_taken, illegal  out  1 each  single-cycle status pulses.

Function
REQ-015 SHALL implement FSM states IDLE, DECODE, EXEC, MEM, WB; inst_ready=1 only in IDLE.
REQ-016 SHALL latch inst on inst_valid&&inst_ready and enter DECODE next cycle; inst is ignored in every other state.
REQ-017 SHALL support: R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23; sw 0x2B; beq 0x04.
REQ-018 SHALL use ALUControl 010 add, 110 sub, 000 and, 001 or, 111 slt (signed); lw/sw/addi use 010, beq uses 110.
REQ-019 SHALL sign-extend the 16-bit immediate to XLEN; all arithmetic is modulo 2^XLEN.
REQ-020 SHALL sequence: R-type/addi DECODE->EXEC->WB; lw DECODE->EXEC->MEM->WB; sw DECODE->EXEC->MEM; beq DECODE->EXEC; each path then returns to IDLE.
REQ-021 SHALL pulse done for one cycle in the final state of each instruction (WB, MEM for sw, EXEC for beq).
REQ-022 SHALL enter IDLE from DECODE with a one-cycle illegal pulse, and no register, memory or pc update, on an unsupported opcode/funct or any register index >= NREG.
REQ-023 SHALL read register 0 as zero and ignore writes to it.
REQ-024 SHALL register the rs/rt operands in DECODE; writeonmem = rt value and holds until the next DECODE.
REQ-025 SHALL register aluresult at the end of EXEC and hold it until the next EXEC.
REQ-026 SHALL drive RegDst, ALUSrc, MemtoReg, ALUControl from DECODE until retire and 0 in IDLE.
REQ-027 SHALL assert MemWrite only in the MEM cycle of sw and RegWrite only in the WB cycle, one cycle each.
REQ-028 SHALL address data memory with word index aluresult[..:2] modulo DMEM_DEPTH; bits [1:0] are ignored.
REQ-029 SHALL make store data visible to a lw that starts in the following cycle.
REQ-030 SHALL update pc at retire: pc+4, or pc+4+(imm<<2) for a taken beq with a one-cycle branch_taken pulse in EXEC.
REQ-031 SHALL compute pc wrap-around modulo 2^XLEN.

Reset
REQ-032 SHALL on reset, immediately and in any state, return the FSM to IDLE and drive pc, aluresult, writeonmem, all controls and all pulses to 0.
REQ-033 SHALL clear the register file to zero on reset; data-memory contents are not reset.
REQ-034 SHALL abort any in-flight instruction on reset mid-operation, with no further register or memory write.

Verification
REQ-035 SHALL verify: reset, inst=32'h20020005 (addi $2,$0,5) -> done in WB 3 cycles after accept, aluresult=5, RegWrite one cycle, pc=4.
REQ-036 SHALL verify: then 32'h00421820 (add $3,$2,$2) -> aluresult=10, RegDst=1, ALUControl=010, pc=8.
REQ-037 SHALL verify: 32'hAC030004 (sw) then 32'h8C040004 (lw) then 32'h00802820 (add $5,$4,$0) -> MemWrite one cycle with writeonmem=10, lw aluresult=4, final aluresult=10.
REQ-038 SHALL verify: 32'h1042FFFF (beq $2,$2,-1) -> branch_taken pulse, done in EXEC, pc unchanged, no RegWrite/MemWrite.
REQ-039 SHALL verify: 32'hFC000000 -> illegal pulse from DECODE, pc and registers unchanged, inst_ready=1 next cycle.
REQ-040 SHALL verify: reset asserted during the MEM cycle of sw -> MemWrite falls without a clock edge, target word unchanged, pc=0, inst_ready=1 after release.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: add/sub/and/or/slt, addi, lw, sw and beq.
// An instruction is accepted in IDLE and walks DECODE/EXEC/MEM/WB. Every
// status output comes straight from a flop, so each value is set on the
// transition into the state in which it must be visible.
module mips_multicycle_core #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int DMEM_DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    output logic            inst_ready,
    output logic [XLEN-1:0] aluresult,
    output logic [XLEN-1:0] writeonmem,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic [2:0]      ALUControl,
    output logic [XLEN-1:0] pc,
    output logic            done,
    output logic            branch_taken,
    output logic            illegal
);
    localparam int RW = $clog2(NREG);
    localparam int DW = $clog2(DMEM_DEPTH);
    localparam logic [5:0] NREG_W  = 6'(NREG);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    // Decoded instruction: instruction class plus the datapath selects.
    typedef struct packed {
        logic       legal;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [2:0] alu_ctl;
    } dec_t;

    // Decode an instruction word; anything unsupported decodes to all zeros.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic idx_ok;
        logic rd_ok;
        d      = '0;
        idx_ok = ({1'b0, ins[25:21]} < NREG_W) && ({1'b0, ins[20:16]} < NREG_W);
        rd_ok  = ({1'b0, ins[15:11]} < NREG_W);
        case (ins[31:26])
            OP_R: begin
                d.reg_dst = 1'b1;
                d.legal   = idx_ok && rd_ok;
                case (ins[5:0])
                    6'h20:   d.alu_ctl = 3'b010;
                    6'h22:   d.alu_ctl = 3'b110;
                    6'h24:   d.alu_ctl = 3'b000;
                    6'h25:   d.alu_ctl = 3'b001;
                    6'h2A:   d.alu_ctl = 3'b111;
                    default: d.legal   = 1'b0;
                endcase
            end
            OP_ADDI: begin d.legal = idx_ok; d.alu_src = 1'b1; d.alu_ctl = 3'b010; end
            OP_LW:   begin d.legal = idx_ok; d.is_lw = 1'b1; d.alu_src = 1'b1;
                           d.mem_to_reg = 1'b1; d.alu_ctl = 3'b010; end
            OP_SW:   begin d.legal = idx_ok; d.is_sw = 1'b1; d.alu_src = 1'b1;
                           d.alu_ctl = 3'b010; end
            OP_BEQ:  begin d.legal = idx_ok; d.is_beq = 1'b1; d.alu_ctl = 3'b110; end
            default: d.legal = 1'b0;
        endcase
        return d.legal ? d : '0;
    endfunction

    // ALU; slt compares as signed two's complement.
    function automatic logic [XLEN-1:0] alu(input logic [2:0] ctl,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        case (ctl)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: return a + b;
        endcase
    endfunction

    state_t          state_q, state_d;
    dec_t            dec_q, dec_d;
    logic [25:0]     inst_q, inst_d;
    logic [XLEN-1:0] a_q, a_d, wom_q, wom_d, alu_q, alu_d, mdr_q, mdr_d, pc_q, pc_d;
    logic            mem_write_q, mem_write_d, reg_write_q, reg_write_d;
    logic            done_q, done_d, br_q, br_d, ill_q, ill_d;

    logic [XLEN-1:0] rf_q   [NREG];
    logic [XLEN-1:0] dmem_q [DMEM_DEPTH];

    dec_t            dec_in_s;
    logic [XLEN-1:0] rs_val_s, rt_val_s, imm_s, pc_next_s, wdata_s;
    logic [RW-1:0]   wdest_s;
    logic            retire_s;

    assign dec_in_s  = decode(inst);
    assign rs_val_s  = rf_q[inst_q[21 +: RW]];
    assign rt_val_s  = rf_q[inst_q[16 +: RW]];
    assign imm_s     = XLEN'($signed(inst_q[15:0]));
    assign pc_next_s = pc_q + XLEN'(4) + (br_q ? (imm_s << 2) : {XLEN{1'b0}});
    assign wdest_s   = dec_q.reg_dst ? inst_q[11 +: RW] : inst_q[16 +: RW];
    assign wdata_s   = dec_q.mem_to_reg ? mdr_q : alu_q;
    assign retire_s  = (state_q == S_WB) || (state_q == S_MEM && dec_q.is_sw) ||
                       (state_q == S_EXEC && dec_q.is_beq);

    // Next-state and datapath register inputs for the instruction sequencer.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        a_d         = a_q;
        wom_d       = wom_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        pc_d        = retire_s ? pc_next_s : pc_q;
        dec_d       = retire_s ? '0 : dec_q;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        done_d      = 1'b0;
        br_d        = 1'b0;
        ill_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    inst_d  = inst[25:0];
                    dec_d   = dec_in_s;
                    ill_d   = !dec_in_s.legal;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (!dec_q.legal) begin
                    state_d = S_IDLE;
                end else begin
                    a_d     = rs_val_s;
                    wom_d   = rt_val_s;
                    done_d  = dec_q.is_beq;
                    br_d    = dec_q.is_beq && (rs_val_s == rt_val_s);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu(dec_q.alu_ctl, a_q, dec_q.alu_src ? imm_s : wom_q);
                if (dec_q.is_beq) begin
                    state_d = S_IDLE;
                end else if (dec_q.is_lw || dec_q.is_sw) begin
                    mem_write_d = dec_q.is_sw;
                    done_d      = dec_q.is_sw;
                    state_d     = S_MEM;
                end else begin
                    reg_write_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_WB;
                end
            end
            S_MEM: begin
                if (dec_q.is_sw) begin
                    state_d = S_IDLE;
                end else begin
                    mdr_d       = dmem_q[alu_q[2 +: DW]];
                    reg_write_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dec_q       <= '0;
            inst_q      <= 26'd0;
            a_q         <= {XLEN{1'b0}};
            wom_q       <= {XLEN{1'b0}};
            alu_q       <= {XLEN{1'b0}};
            mdr_q       <= {XLEN{1'b0}};
            pc_q        <= {XLEN{1'b0}};
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            done_q      <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            inst_q      <= inst_d;
            a_q         <= a_d;
            wom_q       <= wom_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            pc_q        <= pc_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            done_q      <= done_d;
            br_q        <= br_d;
            ill_q       <= ill_d;
        end
    end

    // Register file: cleared on reset, written in WB; register 0 stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= {XLEN{1'b0}};
        end else if (reg_write_q && (wdest_s != RW'(0))) begin
            rf_q[wdest_s] <= wdata_s;
        end
    end

    // Data memory: word-addressed, written at the end of the sw MEM cycle.
    always_ff @(posedge clk) begin
        if (mem_write_q) begin
            dmem_q[alu_q[2 +: DW]] <= wom_q;
        end
    end

    assign inst_ready   = (state_q == S_IDLE);
    assign aluresult    = alu_q;
    assign writeonmem   = wom_q;
    assign MemWrite     = mem_write_q;
    assign RegWrite     = reg_write_q;
    assign RegDst       = dec_q.reg_dst;
    assign ALUSrc       = dec_q.alu_src;
    assign MemtoReg     = dec_q.mem_to_reg;
    assign ALUControl   = dec_q.alu_ctl;
    assign pc           = pc_q;
    assign done         = done_q;
    assign branch_taken = br_q;
    assign illegal      = ill_q;
endmodule
